// File: rtl/noc_endpoint.sv
// rtl/noc_endpoint.sv - NoC local endpoint: registered TX flit and RX FIFO toward the user
// Optional NOC_EP_DEST_CHECK_EN: drop and count received flits not addressed to this node.
module noc_endpoint #(
  parameter int DATA_WIDTH = 216,
  parameter int POS_WIDTH  = 4,
  parameter int POS_X      = 1,
  parameter int POS_Y      = 1,
  parameter int RX_DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic [DATA_WIDTH-1:0]             noc_out_data,
  output logic                              noc_out_valid,
  input  logic                              noc_out_busy,
  input  logic [DATA_WIDTH-1:0]             noc_in_data,
  input  logic                              noc_in_valid,
  output logic                              noc_in_busy,
  input  logic [DATA_WIDTH-4*POS_WIDTH-1:0] tx_payload,
  input  logic [POS_WIDTH-1:0]              tx_dst_x,
  input  logic [POS_WIDTH-1:0]              tx_dst_y,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic [DATA_WIDTH-4*POS_WIDTH-1:0] rx_payload,
  output logic [POS_WIDTH-1:0]              rx_src_x,
  output logic [POS_WIDTH-1:0]              rx_src_y,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [15:0]                       drop_count
);

  localparam int PW = DATA_WIDTH - 4*POS_WIDTH;
  localparam int EW = PW + 2*POS_WIDTH;
  localparam int AW = (RX_DEPTH > 2) ? $clog2(RX_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [POS_WIDTH-1:0] MY_X = POS_WIDTH'(POS_X);
  localparam logic [POS_WIDTH-1:0] MY_Y = POS_WIDTH'(POS_Y);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t tx_state, tx_state_nxt;
  logic      tx_xfer;

  always_comb begin
    tx_state_nxt  = tx_state;
    tx_ready      = 1'b1;
    noc_out_valid = 1'b0;
    case (tx_state)
      TX_SEND: begin
        tx_ready      = ~noc_out_busy;
        noc_out_valid = 1'b1;
      end
      default: ;
    endcase
    tx_xfer = tx_valid & tx_ready;
    // A new user flit wins over returning to idle so back-to-back flits stream.
    if (tx_xfer)
      tx_state_nxt = TX_SEND;
    else if (noc_out_valid && !noc_out_busy)
      tx_state_nxt = TX_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state     <= TX_IDLE;
      noc_out_data <= '0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_xfer)
        noc_out_data <= {tx_dst_x, tx_dst_y, MY_X, MY_Y, tx_payload};
    end
  end

  // Only source coordinates and payload are kept; the destination is consumed on entry.
  logic [EW-1:0] rx_mem [RX_DEPTH];
  logic [EW-1:0] rx_head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_accept, rx_push, rx_pop;

  assign noc_in_busy = (rx_count == CW'(RX_DEPTH));
  assign rx_valid    = (rx_count != '0);
  assign rx_accept   = noc_in_valid & ~noc_in_busy;
  assign rx_pop      = rx_valid & rx_ready;

  assign rx_head    = rx_mem[rd_ptr];
  assign rx_payload = rx_head[PW-1:0];
  assign rx_src_y   = rx_head[PW+POS_WIDTH-1 -: POS_WIDTH];
  assign rx_src_x   = rx_head[EW-1 -: POS_WIDTH];

`ifdef NOC_EP_DEST_CHECK_EN
  logic dst_hit;
  assign dst_hit = (noc_in_data[DATA_WIDTH-1 -: POS_WIDTH] == MY_X) &&
                   (noc_in_data[DATA_WIDTH-POS_WIDTH-1 -: POS_WIDTH] == MY_Y);
  assign rx_push = rx_accept & dst_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_count <= '0;
    else if (rx_accept && !dst_hit && drop_count != 16'hFFFF)
      drop_count <= drop_count + 16'd1;
  end
`else
  logic unused_dst;
  assign unused_dst = ^noc_in_data[DATA_WIDTH-1:EW];
  assign rx_push    = rx_accept;
  assign drop_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[wr_ptr] <= noc_in_data[EW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push)
        wr_ptr <= AW'((wr_ptr + 1'b1) % RX_DEPTH);
      if (rx_pop)
        rd_ptr <= AW'((rd_ptr + 1'b1) % RX_DEPTH);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_endpoint.sv
// tb/tb_noc_endpoint.sv - scoreboard bench for noc_endpoint (POS 1,1, RX_DEPTH 4)
module tb_noc_endpoint;
  localparam int DW  = 216;
  localparam int PWI = 4;
  localparam int PW  = DW - 4*PWI;
  localparam int EW  = PW + 2*PWI;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [DW-1:0]  noc_out_data;
  logic           noc_out_valid;
  logic           noc_out_busy = 1'b0;
  logic [DW-1:0]  noc_in_data = '0;
  logic           noc_in_valid = 1'b0;
  logic           noc_in_busy;
  logic [PW-1:0]  tx_payload = '0;
  logic [PWI-1:0] tx_dst_x = '0;
  logic [PWI-1:0] tx_dst_y = '0;
  logic           tx_valid = 1'b0;
  logic           tx_ready;
  logic [PW-1:0]  rx_payload;
  logic [PWI-1:0] rx_src_x;
  logic [PWI-1:0] rx_src_y;
  logic           rx_valid;
  logic           rx_ready = 1'b0;
  logic [15:0]    drop_count;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] txq[$];
  logic [EW-1:0] rxq[$];

  noc_endpoint #(.DATA_WIDTH(DW), .POS_WIDTH(PWI), .POS_X(1), .POS_Y(1), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .noc_out_data(noc_out_data), .noc_out_valid(noc_out_valid), .noc_out_busy(noc_out_busy),
    .noc_in_data(noc_in_data), .noc_in_valid(noc_in_valid), .noc_in_busy(noc_in_busy),
    .tx_payload(tx_payload), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_payload(rx_payload), .rx_src_x(rx_src_x), .rx_src_y(rx_src_y),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] flit(input logic [PWI-1:0] dx, input logic [PWI-1:0] dy,
                                         input logic [PWI-1:0] sx, input logic [PWI-1:0] sy,
                                         input logic [PW-1:0] p);
    return {dx, dy, sx, sy, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: transfers are judged at the falling edge, ahead of the rising edge that commits them.
  always @(negedge clk) begin
    if (rst) begin
      if (noc_out_valid && !noc_out_busy) begin
        if (txq.size() == 0) chk("tx_unexpected", 1, 0);
        else chk("tx_flit", noc_out_data, txq.pop_front());
      end
      if (rx_valid && rx_ready) begin
        if (rxq.size() == 0) chk("rx_unexpected", 1, 0);
        else chk("rx_entry", {rx_src_x, rx_src_y, rx_payload}, rxq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] f;
    #1 rst = 1'b0;
    #1;
    chk("rst_out_valid", noc_out_valid, 0);
    chk("rst_out_data", noc_out_data, 0);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_in_busy", noc_in_busy, 0);
    chk("rst_drop", drop_count, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;

    // Single flit, latency 1, header 0x2311
    tx_payload = PW'(12'hABC); tx_dst_x = 4'd2; tx_dst_y = 4'd3; tx_valid = 1'b1;
    txq.push_back(flit(2, 3, 1, 1, PW'(12'hABC)));
    #1 chk("tx_ready_idle", tx_ready, 1);
    step(); tx_valid = 1'b0;
    #1;
    chk("tx_valid_lat1", noc_out_valid, 1);
    chk("tx_hdr", noc_out_data[215:200], 16'h2311);
    chk("tx_payload_field", noc_out_data[PW-1:0], 12'hABC);
    step(); #1 chk("tx_valid_after", noc_out_valid, 0);

    // Backpressure for 3 cycles with a pending user flit that must not be taken
    f = flit(0, 5, 1, 1, PW'(12'h123));
    tx_payload = PW'(12'h123); tx_dst_x = 4'd0; tx_dst_y = 4'd5; tx_valid = 1'b1;
    txq.push_back(f);
    step();
    noc_out_busy = 1'b1;
    tx_payload = PW'(12'h999); tx_dst_x = 4'd4; tx_dst_y = 4'd4;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("busy_hold_valid", noc_out_valid, 1);
      chk("busy_tx_ready", tx_ready, 0);
      chk("busy_hold_data", noc_out_data, f);
      step();
    end
    noc_out_busy = 1'b0;
    txq.push_back(flit(4, 4, 1, 1, PW'(12'h999)));
    step(); tx_valid = 1'b0;
    #1 chk("busy_then_next", noc_out_valid, 1);
    step(); #1 chk("busy_done_idle", noc_out_valid, 0);

    // Back-to-back flits, one per cycle
    for (int i = 0; i < 3; i++) begin
      tx_payload = PW'(i + 16); tx_dst_x = PWI'(i); tx_dst_y = 4'd7; tx_valid = 1'b1;
      txq.push_back(flit(PWI'(i), 7, 1, 1, PW'(i + 16)));
      #1 chk("tx_ready_b2b", tx_ready, 1);
      step();
    end
    tx_valid = 1'b0;
    #1 chk("b2b_last_valid", noc_out_valid, 1);
    step(); #1 chk("b2b_idle", noc_out_valid, 0);
    chk("b2b_drained", txq.size(), 0);

    // Fill FIFO, refuse a 5th, drain in order
    rx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      noc_in_data = flit(1, 1, PWI'(i), PWI'(i + 1), PW'(256 + i)); noc_in_valid = 1'b1;
      rxq.push_back({PWI'(i), PWI'(i + 1), PW'(256 + i)});
      #1 chk("fill_in_busy", noc_in_busy, 0);
      step();
    end
    noc_in_data = flit(1, 1, 4'd9, 4'd9, PW'(12'h555));
    #1;
    chk("full_in_busy", noc_in_busy, 1);
    chk("full_head_stable", rx_payload, 256);
    step(); #1 chk("full_in_busy2", noc_in_busy, 1);
    noc_in_valid = 1'b0; rx_ready = 1'b1;
    repeat (4) step();
    rx_ready = 1'b0;
    #1;
    chk("drain_rx_valid", rx_valid, 0);
    chk("drain_in_busy", noc_in_busy, 0);

    // Simultaneous push and pop at count 2
    for (int i = 0; i < 2; i++) begin
      noc_in_data = flit(1, 1, 4'd2, 4'd3, PW'(513 + i)); noc_in_valid = 1'b1;
      rxq.push_back({4'd2, 4'd3, PW'(513 + i)});
      step();
    end
    noc_in_data = flit(1, 1, 4'd2, 4'd3, PW'(515)); rx_ready = 1'b1;
    rxq.push_back({4'd2, 4'd3, PW'(515)});
    step(); rx_ready = 1'b0;
    #1;
    chk("pp_head_adv", rx_payload, 514);
    chk("pp_in_busy", noc_in_busy, 0);
    noc_in_data = flit(1, 1, 4'd2, 4'd3, PW'(516));
    rxq.push_back({4'd2, 4'd3, PW'(516)});
    step(); #1 chk("pp_count3", noc_in_busy, 0);
    noc_in_data = flit(1, 1, 4'd2, 4'd3, PW'(517));
    rxq.push_back({4'd2, 4'd3, PW'(517)});
    step(); #1 chk("pp_count4", noc_in_busy, 1);
    noc_in_valid = 1'b0; rx_ready = 1'b1;
    repeat (4) step();
    rx_ready = 1'b0;
    #1;
    chk("pp_drain_valid", rx_valid, 0);
    chk("pp_rxq_empty", rxq.size(), 0);

    // Misrouted flit (3,0)
    noc_in_data = flit(3, 0, 4'd2, 4'd2, PW'(8'h77)); noc_in_valid = 1'b1;
`ifndef NOC_EP_DEST_CHECK_EN
    rxq.push_back({4'd2, 4'd2, PW'(8'h77)});
`endif
    step(); noc_in_valid = 1'b0;
    #1;
`ifdef NOC_EP_DEST_CHECK_EN
    chk("misroute_rx_valid", rx_valid, 0);
    chk("misroute_drop", drop_count, 1);
`else
    chk("misroute_rx_valid", rx_valid, 1);
    chk("misroute_drop", drop_count, 0);
`endif
    rx_ready = 1'b1; step(); rx_ready = 1'b0;

    // Asynchronous reset with a held TX flit and 3 FIFO entries
    tx_payload = PW'(8'h42); tx_dst_x = 4'd5; tx_dst_y = 4'd5; tx_valid = 1'b1; noc_out_busy = 1'b1;
    step(); tx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      noc_in_data = flit(1, 1, 4'd1, 4'd2, PW'(i + 3)); noc_in_valid = 1'b1;
      step();
    end
    noc_in_valid = 1'b0;
    #1;
    chk("pre_rst_rx_valid", rx_valid, 1);
    chk("pre_rst_out_valid", noc_out_valid, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_valid", noc_out_valid, 0);
    chk("arst_out_data", noc_out_data, 0);
    chk("arst_rx_valid", rx_valid, 0);
    chk("arst_in_busy", noc_in_busy, 0);
    chk("arst_tx_ready", tx_ready, 1);
    chk("arst_drop", drop_count, 0);
    noc_out_busy = 1'b0;
    step(); rst = 1'b1;
    step(); #1;
    chk("post_rst_out_valid", noc_out_valid, 0);
    chk("post_rst_rx_valid", rx_valid, 0);

    // Recovery flit after reset
    tx_payload = PW'(12'hDEF); tx_dst_x = 4'd6; tx_dst_y = 4'd6; tx_valid = 1'b1;
    txq.push_back(flit(6, 6, 1, 1, PW'(12'hDEF)));
    step(); tx_valid = 1'b0;
    step(); step();
    chk("end_txq_empty", txq.size(), 0);
    chk("end_rxq_empty", rxq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/noc_endpoint.md
NOC_ENDPOINT -- requirements
Module: noc_endpoint

Interface
REQ-001 The block SHALL use one clock, clk; reset is rst, asynchronous and active-low.
REQ-002 Parameter DATA_WIDTH, 216, flit width in bits.
REQ-003 Parameter POS_WIDTH, 4, width of one mesh coordinate.
REQ-004 Parameter POS_X, 1, this node's X coordinate.
REQ-005 Parameter POS_Y, 1, this node's Y coordinate.
REQ-006 Parameter RX_DEPTH, 4, receive FIFO entries; power of two, at least 2. PW = DATA_WIDTH-4*POS_WIDTH throughout.
REQ-007 clk  in  1  clock.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 noc_out_data  out  DATA_WIDTH  flit to router local input.
REQ-010 noc_out_valid  out  1  flit present.
REQ-011 noc_out_busy  in  1  router refuses flit.
REQ-012 noc_in_data  in  DATA_WIDTH  flit from router local output.
REQ-013 noc_in_valid  in  1  flit present.
REQ-014 noc_in_busy  out  1  endpoint refuses flit.
REQ-015 tx_payload  in  PW  user payload to send.
REQ-016 tx_dst_x, tx_dst_y  in  POS_WIDTH each  destination coordinates.
REQ-017 tx_valid / tx_ready  in / out  1 each  user send handshake.
REQ-018 rx_payload  out  PW  received payload.
REQ-019 rx_src_x, rx_src_y  out  POS_WIDTH each  sender coordinates.
REQ-020 rx_valid / rx_ready  out / in  1 each  user receive handshake.
REQ-021 drop_count  out  16  misrouted-flit counter (see Configuration).

Function
REQ-022 Flit layout SHALL be, MSB first: dst_x, dst_y, src_x, src_y, payload[PW-1:0].
REQ-023 Network transfer SHALL occur on a clk edge where valid=1 and busy=0; user transfer where valid=1 and ready=1.
REQ-024 TX FSM has states TX_IDLE and TX_SEND. In TX_IDLE, tx_ready=1. In TX_SEND, tx_ready=~noc_out_busy.
REQ-025 On a user transfer, the flit {tx_dst_x, tx_dst_y, POS_X, POS_Y, tx_payload} SHALL be registered. State goes to TX_SEND and noc_out_valid=1 on the next cycle (latency 1).
REQ-026 In TX_SEND with noc_out_busy=1, noc_out_data and noc_out_valid SHALL hold stable.
REQ-027 On a network transfer with no new user transfer, the block SHALL return to TX_IDLE. With a simultaneous user transfer, it stays in TX_SEND with the new flit; back-to-back flits run one per cycle.
REQ-028 RX side SHALL be a RX_DEPTH-entry FIFO with a registered occupancy count. noc_in_busy = (count==RX_DEPTH), combinational from the count.
REQ-029 rx_valid = (count!=0). rx_payload/rx_src_x/rx_src_y SHALL present the head entry and stay stable while rx_ready=0.
REQ-030 Simultaneous push and pop SHALL leave count unchanged.
REQ-031 When full, no push occurs even if a pop happens that cycle, since busy is already 1. When empty, a pop is impossible.
REQ-032 Pointers SHALL wrap modulo RX_DEPTH. Order is FIFO.

Reset
REQ-033 While rst=0: TX_IDLE, noc_out_valid=0, noc_out_data=0, tx_ready=1, FIFO count and pointers=0, rx_valid=0, noc_in_busy=0, drop_count=0.
REQ-034 Reset mid-transfer SHALL discard the held TX flit and all FIFO contents immediately, without waiting for a clock edge.

Configuration
REQ-035 With NOC_EP_DEST_CHECK_EN defined: an accepted flit whose dst differs from (POS_X,POS_Y) SHALL be consumed but not pushed, and drop_count increments, saturating at 0xFFFF.
REQ-036 Without NOC_EP_DEST_CHECK_EN: every accepted flit is pushed and drop_count is tied to 0.

Verification (POS_X=POS_Y=1, RX_DEPTH=4)
REQ-037 tx_payload=0xABC, dst (2,3), noc_out_busy=0 -> next cycle noc_out_valid=1, data[215:200]=0x2311, payload field=0xABC; valid=0 the cycle after.
REQ-038 noc_out_busy=1 for 3 cycles during TX_SEND -> data/valid stable and tx_ready=0 for those 3 cycles; transfer completes on the first busy=0 edge.
REQ-039 Push 4 flits with rx_ready=0 -> noc_in_busy=1 after the 4th and a 5th offered flit is not taken; then rx_ready=1 -> 4 payloads pop in order, count returns to 0.
REQ-040 Count=2 with push and pop on the same edge -> count stays 2 and head advances.
REQ-041 Macro defined, flit dst (3,0) -> consumed, rx_valid stays 0, drop_count=1. Macro undefined, same flit -> rx_valid=1.
REQ-042 rst=0 asserted while noc_out_valid=1 and FIFO holds 3 flits -> noc_out_valid=0, rx_valid=0, noc_in_busy=0 before the next clk edge.
